// File: rtl/bus_host_arbiter_if.sv
// Host-side port arrays and the single downstream device port shared by bus_host_arbiter.
// slave = arbiter side, master = hosts plus downstream device (environment side).
interface bus_host_arbiter_if #(
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic                    host_req_i    [NrHosts];
  logic                    host_gnt_o    [NrHosts];
  logic [AddressWidth-1:0] host_addr_i   [NrHosts];
  logic                    host_we_i     [NrHosts];
  logic [DataWidth/8-1:0]  host_be_i     [NrHosts];
  logic [DataWidth-1:0]    host_wdata_i  [NrHosts];
  logic                    host_rvalid_o [NrHosts];
  logic [DataWidth-1:0]    host_rdata_o  [NrHosts];
  logic                    host_err_o    [NrHosts];

  logic                    dev_req_o;
  logic [AddressWidth-1:0] dev_addr_o;
  logic                    dev_we_o;
  logic [DataWidth/8-1:0]  dev_be_o;
  logic [DataWidth-1:0]    dev_wdata_o;
  logic                    dev_gnt_i;
  logic                    dev_rvalid_i;
  logic [DataWidth-1:0]    dev_rdata_i;
  logic                    dev_err_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
    output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
  );
endinterface

// File: rtl/bus_host_arbiter.sv
// Round-robin N:1 bus arbiter with in-order response-ID queue routing responses back to the issuer.
// Define BUS_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bus_host_arbiter_if.slave bus,
  output logic              busy_o,
  output logic              unexp_rsp_o
);
  localparam int IdW  = $clog2(NrHosts);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]  ptr_q, ptr_d, lock_id_q, lock_id_d, winner, head;
  logic            lock_q, lock_d, winner_valid, can_issue, dev_req, hs, push, pop;
  logic [IdW:0]    cand;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdW-1:0]  fifo_q [MaxOutstanding];
  logic [IdW-1:0]  fifo_d [MaxOutstanding];

  // A still-requesting locked host bypasses the search; otherwise scan from ptr, nearest wins.
  always_comb begin
    winner       = '0;
    winner_valid = 1'b0;
    cand         = '0;
    if (lock_q && bus.host_req_i[lock_id_q]) begin
      winner       = lock_id_q;
      winner_valid = 1'b1;
    end else begin
      for (int k = NrHosts - 1; k >= 0; k--) begin
        cand = {1'b0, ptr_q} + (IdW+1)'(k);
        if (cand >= (IdW+1)'(NrHosts)) cand = cand - (IdW+1)'(NrHosts);
        if (bus.host_req_i[cand[IdW-1:0]]) begin
          winner       = cand[IdW-1:0];
          winner_valid = 1'b1;
        end
      end
    end
  end

  assign can_issue   = (count_q < CntW'(MaxOutstanding));
  assign dev_req     = can_issue & winner_valid & ~rst_i;
  assign hs          = dev_req & bus.dev_gnt_i;
  assign push        = hs;
  assign pop         = bus.dev_rvalid_i & (count_q != '0) & ~rst_i;
  assign head        = fifo_q[rd_ptr_q];
  assign busy_o      = (count_q != '0);
  assign unexp_rsp_o = bus.dev_rvalid_i & (count_q == '0) & ~rst_i;

  assign bus.dev_req_o   = dev_req;
  assign bus.dev_addr_o  = dev_req ? bus.host_addr_i[winner]  : '0;
  assign bus.dev_we_o    = dev_req ? bus.host_we_i[winner]    : 1'b0;
  assign bus.dev_be_o    = dev_req ? bus.host_be_i[winner]    : '0;
  assign bus.dev_wdata_o = dev_req ? bus.host_wdata_i[winner] : '0;

  for (genvar i = 0; i < NrHosts; i++) begin : g_host
    assign bus.host_gnt_o[i]    = hs  && (winner == IdW'(i));
    assign bus.host_rvalid_o[i] = pop && (head == IdW'(i));
    assign bus.host_rdata_o[i]  = bus.dev_rdata_i;
    assign bus.host_err_o[i]    = bus.dev_err_i;
  end

  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q & bus.host_req_i[lock_id_q];
    lock_id_d = lock_id_q;
    if (dev_req && !bus.dev_gnt_i) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end
    if (hs) begin
      lock_d = 1'b0;
      ptr_d  = (winner == IdW'(NrHosts - 1)) ? '0 : winner + IdW'(1);
    end
`ifdef BUS_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
`endif
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fifo_q    <= fifo_d;
    end
  end
endmodule

// File: tb/tb_bus_host_arbiter.sv
// Scoreboard bench for bus_host_arbiter: stimulus queues expected grants/responses, a monitor
// pops and compares whenever the DUT shows a grant, rvalid or unexpected-response pulse.
module tb_bus_host_arbiter;
  localparam int N = 2, DW = 32, AW = 32, MO = 2;
  localparam logic [31:0] A0 = 32'h1000_0040, A1 = 32'h2000_0080;
  localparam logic [31:0] D0 = 32'hEFFF_0040, D1 = 32'hDFFF_0080;  // device returns addr ^ FFFF_0000

  logic clk = 1'b0;
  logic rst;
  logic busy, unexp;

  bus_host_arbiter_if #(.NrHosts(N), .DataWidth(DW), .AddressWidth(AW)) bif ();

  bus_host_arbiter #(
    .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bif), .busy_o(busy), .unexp_rsp_o(unexp)
  );

  always #5 clk = ~clk;

  typedef struct { int host; logic [31:0] val; } exp_t;
  exp_t        exp_gnt[$];
  exp_t        exp_rsp[$];
  int          exp_unexp = 0;
  logic [31:0] pend[$];
  logic        hold_rsp = 1'b0;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(int h, logic r, logic [31:0] a);
    bif.host_req_i[h]   = r;
    bif.host_addr_i[h]  = a;
    bif.host_wdata_i[h] = a ^ 32'h5555_5555;
    bif.host_we_i[h]    = 1'b0;
    bif.host_be_i[h]    = 4'hF;
  endtask

  function automatic exp_t mk(int h, logic [31:0] v);
    exp_t e;
    e.host = h;
    e.val  = v;
    return e;
  endfunction

  // Device model: one-cycle response latency, stalled while hold_rsp is set.
  always @(negedge clk)
    if (bif.dev_req_o && bif.dev_gnt_i) pend.push_back(bif.dev_addr_o ^ 32'hFFFF_0000);

  initial begin
    bif.dev_rvalid_i = 1'b0;
    bif.dev_rdata_i  = '0;
    bif.dev_err_i    = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!hold_rsp && pend.size() > 0) begin
        bif.dev_rvalid_i = 1'b1;
        bif.dev_rdata_i  = pend.pop_front();
      end else begin
        bif.dev_rvalid_i = 1'b0;
        bif.dev_rdata_i  = '0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (bif.host_gnt_o[i]) begin
        if (exp_gnt.size() == 0) begin
          n_chk++;
          $display("FAIL gnt_extra: host %0d granted with no grant expected", i);
        end else begin
          e = exp_gnt.pop_front();
          chk("gnt_host", 32'(i), 32'(e.host));
          chk("gnt_addr", bif.dev_addr_o, e.val);
        end
      end
      if (bif.host_rvalid_o[i]) begin
        if (exp_rsp.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_extra: rvalid on host %0d with no response expected", i);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_host", 32'(i), 32'(e.host));
          for (int j = 0; j < N; j++) chk("rsp_rdata", bif.host_rdata_o[j], e.val);
        end
      end
    end
    if (unexp) begin
      n_chk++;
      if (exp_unexp > 0) begin
        exp_unexp--;
        n_pass++;
      end else $display("FAIL unexp_extra: unexp_rsp_o high with no pulse expected");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bif.dev_gnt_i = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0);
    tick(); tick();
    @(negedge clk);
    chk("rst_dev_req", 32'(bif.dev_req_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_unexp", 32'(unexp), 0);
    tick();
    rst = 1'b0;

    // Single host back-to-back
    set_req(0, 1'b1, A0);
    bif.dev_gnt_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_gnt.push_back(mk(0, A0));
      exp_rsp.push_back(mk(0, D0));
    end
    tick(); tick(); tick();
    set_req(0, 1'b0, A0);
    chk("b2b_3grants", 32'(exp_gnt.size()), 0);
    tick(); tick();
    chk("b2b_3rsp", 32'(exp_rsp.size()), 0);
    chk("b2b_idle_busy", 32'(busy), 0);

    // Fairness from reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, A0);
    set_req(1, 1'b1, A1);
`ifdef BUS_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      exp_gnt.push_back(mk(0, A0));
      exp_rsp.push_back(mk(0, D0));
    end
`else
    for (int k = 0; k < 2; k++) begin
      exp_gnt.push_back(mk(0, A0)); exp_rsp.push_back(mk(0, D0));
      exp_gnt.push_back(mk(1, A1)); exp_rsp.push_back(mk(1, D1));
    end
`endif
    tick(); tick(); tick(); tick();
    set_req(0, 1'b0, A0);
    set_req(1, 1'b0, A1);
    chk("rr_4grants", 32'(exp_gnt.size()), 0);
    tick(); tick();
    chk("rr_rsp_done", 32'(exp_rsp.size()), 0);

    // Stall lock: host1 held through 3 ungranted cycles while host0 joins
    bif.dev_gnt_i = 1'b0;
    set_req(1, 1'b1, A1);
    exp_gnt.push_back(mk(1, A1)); exp_rsp.push_back(mk(1, D1));
    exp_gnt.push_back(mk(0, A0)); exp_rsp.push_back(mk(0, D0));
    tick();
    set_req(0, 1'b1, A0);
    @(negedge clk);
    chk("stall_addr1", bif.dev_addr_o, A1);
    chk("stall_wdata", bif.dev_wdata_o, 32'h7555_55D5);
    tick();
    @(negedge clk);
    chk("stall_addr2", bif.dev_addr_o, A1);
    chk("stall_req", 32'(bif.dev_req_o), 1);
    tick();
    bif.dev_gnt_i = 1'b1;
    tick();
    set_req(1, 1'b0, A1);
    tick();
    set_req(0, 1'b0, A0);
    tick(); tick();
    chk("stall_order_done", 32'(exp_gnt.size()), 0);
    chk("stall_rsp_done", 32'(exp_rsp.size()), 0);

    // Queue full: two unanswered grants block the third
    hold_rsp = 1'b1;
    set_req(0, 1'b1, A0);
    for (int k = 0; k < 3; k++) begin
      exp_gnt.push_back(mk(0, A0));
      exp_rsp.push_back(mk(0, D0));
    end
    tick(); tick();
    @(negedge clk);
    chk("full_req_blocked", 32'(bif.dev_req_o), 0);
    chk("full_addr_zero", bif.dev_addr_o, 0);
    chk("full_busy", 32'(busy), 1);
    tick();
    hold_rsp = 1'b0;
    @(negedge clk);
    chk("full_pop_cycle_blocked", 32'(bif.dev_req_o), 0);
    tick();
    @(negedge clk);
    chk("full_resume", 32'(bif.dev_req_o), 1);
    tick();
    set_req(0, 1'b0, A0);
    tick(); tick();
    chk("full_gnt_done", 32'(exp_gnt.size()), 0);
    chk("full_rsp_done", 32'(exp_rsp.size()), 0);

    // Out-of-band response with empty queue
    tick();
    pend.push_back(32'hDEAD_BEEF);
    exp_unexp++;
    @(negedge clk);
    chk("oob_no_rvalid0", 32'(bif.host_rvalid_o[0]), 0);
    chk("oob_no_rvalid1", 32'(bif.host_rvalid_o[1]), 0);
    tick(); tick();
    chk("oob_pulse_seen", 32'(exp_unexp), 0);

    // Reset with two responses outstanding
    hold_rsp = 1'b1;
    set_req(0, 1'b1, A0);
    exp_gnt.push_back(mk(0, A0));
    exp_gnt.push_back(mk(0, A0));
    tick(); tick();
    set_req(0, 1'b0, A0);
    @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy_after", 32'(busy), 0);
    exp_unexp += 2;
    hold_rsp = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rst_mid_unexp", 32'(exp_unexp), 0);
    chk("rst_mid_busy_end", 32'(busy), 0);

    chk("end_gnt_q", 32'(exp_gnt.size()), 0);
    chk("end_rsp_q", 32'(exp_rsp.size()), 0);
    chk("end_pend_q", 32'(pend.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_host_arbiter.md
# bus_host_arbiter

Round-robin arbiter that shares one downstream bus device port between `NrHosts` bus hosts, such as the core data port, the debug-module system-bus host and a future DMA host. It tracks the host ID of every granted request in an in-order response queue, so each `rvalid`/`rdata`/`err` response returns to the host that issued it. It sits between the hosts and a single device, or in front of the system `bus` when that bus is reduced to one host port.

## Interface
Parameters:
- `NrHosts`, 2, number of requesting hosts (≥2)
- `DataWidth`, 32, data bus width
- `AddressWidth`, 32, address bus width
- `MaxOutstanding`, 2, depth of the response-ID queue (≥1); number of accepted requests still awaiting response

Ports (host-side ports are unpacked arrays of size `NrHosts`):
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset; **one clock; reset is synchronous and active-high**
- `host_req_i`  in  1 ×N  host request
- `host_gnt_o`  out  1 ×N  host grant
- `host_addr_i`  in  AddressWidth ×N  host address
- `host_we_i`  in  1 ×N  host write enable
- `host_be_i`  in  DataWidth/8 ×N  host byte enables
- `host_wdata_i`  in  DataWidth ×N  host write data
- `host_rvalid_o`  out  1 ×N  response valid, routed to the owning host
- `host_rdata_o`  out  DataWidth ×N  response data, broadcast to all hosts
- `host_err_o`  out  1 ×N  response error, broadcast to all hosts
- `dev_req_o`, `dev_addr_o`, `dev_we_o`, `dev_be_o`, `dev_wdata_o`  out  downstream request fields
- `dev_gnt_i`  in  1  downstream grant
- `dev_rvalid_i`, `dev_rdata_i`, `dev_err_i`  in  downstream response
- `busy_o`  out  1  response queue non-empty
- `unexp_rsp_o`  out  1  one-cycle pulse when `dev_rvalid_i` arrives while the queue is empty

## Operation
- State:
  - round-robin pointer `ptr` (0..NrHosts-1)
  - lock flag and `lock_id`
  - response-ID FIFO of `MaxOutstanding` entries, with rd/wr pointers and a `count`
- Accept enable: `can_issue = count < MaxOutstanding`. A pop in the same cycle does not free a slot until the next cycle.
- Winner selection:
  - If locked and `host_req_i[lock_id]`: the winner is `lock_id`.
  - Otherwise: the first requesting host searching `ptr, ptr+1, …` modulo `NrHosts`.
- Request path:
  - `dev_req_o = can_issue & winner_valid`.
  - All `dev_*` request fields are muxed from the winner.
  - When `dev_req_o = 0`, the `dev_*` fields drive 0.
- Handshake: `hs = dev_req_o & dev_gnt_i`.
  - `host_gnt_o[winner] = hs`; all other grants are 0.
  - On `hs`: push the winner ID, set `ptr <= (winner+1) mod NrHosts`, clear the lock.
- Lock rule:
  - If `dev_req_o & ~dev_gnt_i`: set lock with `lock_id <= winner`. The selected host stays stable until granted.
  - If the locked host drops `host_req_i` (a protocol violation), the lock clears and the next cycle re-arbitrates.
- Response path:
  - On `dev_rvalid_i` with `count>0`: pop the FIFO head `h` and assert `host_rvalid_o[h]=1`.
  - `host_rdata_o`/`host_err_o` always mirror `dev_rdata_i`/`dev_err_i` on every host.
  - On `dev_rvalid_i` with `count=0`: drop the response, keep all `host_rvalid_o`=0, and pulse `unexp_rsp_o`.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Pointer width: `$clog2(MaxOutstanding)`, minimum 1. Pointers wrap modulo `MaxOutstanding`, which need not be a power of two.
- `busy_o = (count != 0)`.

## Timing
- Arbitration is combinational: `host_req_i` to `dev_req_o`/`host_gnt_o` has zero cycles of latency.
- Response routing is combinational from `dev_rvalid_i`, so the arbiter adds no response latency.
- All state updates on `posedge clk_i`.
- While `rst_i`=1 at a clock edge, the following clear:
  - `count=0`, `ptr=0`, lock=0, FIFO pointers 0
  - hence `dev_req_o=0`, all `host_gnt_o=0`, all `host_rvalid_o=0`, `busy_o=0`, `unexp_rsp_o=0`
- Reset mid-transaction discards outstanding IDs. Late responses after reset release flag `unexp_rsp_o`.
- Queue full (`count=MaxOutstanding`): `dev_req_o=0` regardless of requests. Issue resumes the cycle after the pop.

## Configuration
- `BUS_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest index wins, and `ptr` is held at 0.
  - The lock rule still applies, so a stalled request is never preempted.
- Not defined: round-robin as described in Operation.

## Test plan
- **Single host, back-to-back:** `NrHosts=2`, `MaxOutstanding=2`. Host0 issues 3 reads, `dev_gnt_i`=1, `dev_rvalid_i` 1 cycle after each grant → 3 grants in 3 cycles; `host_rvalid_o[0]` pulses ×3; `host_rvalid_o[1]` stays 0.
- **Round-robin fairness:** both hosts request continuously, device always grants, reset `ptr=0` → grant order 0,1,0,1. With `BUS_ARB_FIXED_PRIO_EN` → 0,0,0,0.
- **Stall lock:** host1 wins while `dev_gnt_i`=0 for 3 cycles, and host0 raises `host_req_i` during the stall → `dev_addr_o` stays host1's address; host1 is granted first, then host0.
- **Queue full:** `MaxOutstanding=2`, two grants with no response → `dev_req_o`=0 on the third request. `dev_rvalid_i` → head ID returned; `dev_req_o`=1 the next cycle.
- **Out-of-band response:** `dev_rvalid_i`=1 with an empty queue → `unexp_rsp_o` pulses for 1 cycle; no `host_rvalid_o`.
- **Reset mid-operation:** `rst_i`=1 with `count=2` → `busy_o`=0 the next cycle; the pending response then raises `unexp_rsp_o`.
